mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Parametrised, iterative multiply/divide unit; the multi-cycle successor to the single-cycle ALU's MUL/MULH/DIV/MOD paths.
- Sits beside the ALU in the execute stage and covers signed and unsigned multiply-high, divide and modulo.
- Uses valid/ready handshakes on both sides, so execute can stall on it and flush can cancel it.
- Carries a destination tag through unchanged.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even and >= 8.
- TAG_WIDTH, 5, width of the passthrough tag (register write address).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- flush  in  1  abort any in-flight operation.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept (high only in IDLE and flush low).
- in_op  in  3  0 MUL, 1 MULH, 2 MULHU, 3 DIV, 4 DIVU, 5 MOD, 6 MODU, 7 reserved.
- in_a  in  DATA_WIDTH  operand1 (multiplicand/dividend).
- in_b  in  DATA_WIDTH  operand2 (multiplier/divisor).
- in_tag  in  TAG_WIDTH  passthrough tag.
- out_valid  out  1  result valid (registered).
- out_ready  in  1  consumer accepts result.
- out_result  out  DATA_WIDTH  result.
- out_tag  out  TAG_WIDTH  tag captured at accept.

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Accept when in_valid && in_ready at edge E0:
  - Latch op and tag.
  - Latch |a| and |b| (absolute values for signed ops MULH/DIV/MOD; raw values otherwise).
  - Record result sign; load counter with DATA_WIDTH-1; go to CALC.
- CALC, one iteration per cycle, DATA_WIDTH iterations (edges E1..E(DATA_WIDTH)):
  - Multiply: radix-2 shift-add into a 2*DATA_WIDTH product.
  - Divide/mod: restoring divide, one quotient bit per cycle.
  - Counter decrements each iteration; when counter==0, go to FIX.
- FIX, one cycle:
  - Apply sign correction, select the result half, register out_result and out_tag, set out_valid, go to DONE.
  - out_valid therefore rises exactly DATA_WIDTH+1 cycles after the accept edge, for every op.
- DONE:
  - Outputs held stable while out_ready is low.
  - out_valid && out_ready at an edge -> out_valid=0 and IDLE at that edge.
  - in_ready is 0 in DONE; no back-to-back overlap, and the earliest next accept is the cycle after the handshake.
- Result selection:
  - MUL: low half of the product.
  - MULH: high half of the signed product.
  - MULHU: high half of the unsigned product.
  - DIV/DIVU: quotient; signed quotient truncates toward zero.
  - MOD/MODU: remainder; signed remainder takes the dividend's sign.
  - op 7: result 0 at the same latency.
- Divide by zero (b==0), all div/mod ops:
  - quotient = all ones; remainder = a.
  - Fixed latency still applies; no exception output.
- Signed overflow (a = -2^(DATA_WIDTH-1), b = -1): DIV gives a; MOD gives 0.
- Flush:
  - flush high at an edge in any state -> IDLE, out_valid=0, in-flight result discarded.
  - in_ready is forced 0 while flush is high, so no accept occurs that cycle.
  - If flush and out_valid && out_ready coincide, the consumer's transfer stands; the unit still goes IDLE.
- Reset:
  - rst high at an edge, in any state including mid-CALC -> IDLE.
  - All outputs reset to 0: out_valid=0, out_result=0, out_tag=0, counter=0.
  - in_ready is 0 during the reset cycle.
- Inputs are sampled only at the accept edge; changes to in_a/in_b/in_op during CALC have no effect.

Test Plan:
- MUL/MULH basic (DATA_WIDTH=32): MUL a=0x0000_0007, b=0xFFFF_FFFD (-3) -> out_result=0xFFFF_FFEB, out_valid exactly 33 cycles after accept. MULH with the same operands -> 0xFFFF_FFFF.
- MULHU and tag: a=0xFFFF_FFFF, b=0xFFFF_FFFF, tag=5'd17 -> out_result=0xFFFF_FFFE, out_tag=17.
- Signed divide/mod:
  - DIV a=-7 (0xFFFF_FFF9), b=2 -> 0xFFFF_FFFD (-3).
  - MOD with the same operands -> 0xFFFF_FFFF (-1).
  - DIVU with the same operands -> 0x7FFF_FFFC.
- Corner divides:
  - DIV b=0, a=0x1234 -> 0xFFFF_FFFF; MOD b=0, a=0x1234 -> 0x0000_1234.
  - DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000; MOD with the same operands -> 0.
- Backpressure and handshake: hold out_ready=0 for 10 cycles after out_valid -> result and tag stable, in_ready=0 throughout. Raise out_ready -> IDLE next edge, in_ready=1, next request accepted the following cycle.
- Flush/reset mid-operation:
  - Assert flush 5 cycles into CALC -> no out_valid ever for that request.
  - A new DIVU 100/7 accepted next cycle -> 14 after 33 cycles.
  - Repeat with rst instead of flush -> all outputs 0 after the reset edge.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply or restoring divide, one bit per cycle, then one
// fix-up cycle for sign correction and result selection. Valid/ready on both
// sides; flush aborts any in-flight operation. The tag is carried through.
module mdu_iter #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_op,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_result,
   output logic [TAG_WIDTH-1:0]  out_tag
);

   localparam int W     = DATA_WIDTH;
   localparam int CNT_W = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;
   typedef enum logic [2:0] {
      OP_MUL  = 3'd0, OP_MULH = 3'd1, OP_MULHU = 3'd2, OP_DIV  = 3'd3,
      OP_DIVU = 3'd4, OP_MOD  = 3'd5, OP_MODU  = 3'd6, OP_RSVD = 3'd7
   } op_e;

   state_e               state_q, state_d;
   op_e                  op_q, op_d;
   logic [TAG_WIDTH-1:0] tag_q, tag_d;
   logic [W-1:0]         opnd_q, opnd_d;     // multiplicand (mul) or divisor (div)
   logic [2*W-1:0]       acc_q, acc_d;       // {high, low}: product or {remainder, quotient}
   logic                 a_neg_q, a_neg_d;
   logic                 b_neg_q, b_neg_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 out_valid_q, out_valid_d;
   logic [W-1:0]         out_result_q, out_result_d;
   logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;

   op_e          op_in;
   logic         in_signed, in_mul, in_a_neg, in_b_neg;
   logic [W-1:0] in_a_mag, in_b_mag;
   logic [W:0]   mul_sum, div_rem_sh, div_sub;
   logic         div_ge, q_mul;
   logic [2*W-1:0] prod_signed;
   logic [W-1:0] quo, rem, fix_result;

   // Operand conditioning at accept: magnitudes only for the signed ops.
   always_comb begin
      op_in     = op_e'(in_op);
      in_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_MOD);
      in_mul    = (op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_MULHU);
      in_a_neg  = in_signed && in_a[W-1];
      in_b_neg  = in_signed && in_b[W-1];
      in_a_mag  = in_a_neg ? -in_a : in_a;
      in_b_mag  = in_b_neg ? -in_b : in_b;
   end

   // One iteration of each algorithm, plus the fix-up result selection.
   always_comb begin
      q_mul      = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_MULHU);
      mul_sum    = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      div_rem_sh = acc_q[2*W-1:W-1];
      div_ge     = div_rem_sh >= {1'b0, opnd_q};
      div_sub    = div_rem_sh - {1'b0, opnd_q};

      prod_signed = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
      quo         = acc_q[W-1:0];
      rem         = acc_q[2*W-1:W];
      case (op_q)
         OP_MUL:   fix_result = acc_q[W-1:0];
         OP_MULH:  fix_result = prod_signed[2*W-1:W];
         OP_MULHU: fix_result = acc_q[2*W-1:W];
         // A zero divisor yields an all-ones quotient; the remainder path
         // already leaves |a|, which sign correction turns back into a.
         OP_DIV:   fix_result = (opnd_q == '0) ? '1 : ((a_neg_q ^ b_neg_q) ? -quo : quo);
         OP_DIVU:  fix_result = (opnd_q == '0) ? '1 : quo;
         OP_MOD:   fix_result = a_neg_q ? -rem : rem;
         OP_MODU:  fix_result = rem;
         default:  fix_result = '0;
      endcase
   end

   // Control FSM and datapath next state.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      state_d      = state_q;
      op_d         = op_q;
      tag_d        = tag_q;
      opnd_d       = opnd_q;
      acc_d        = acc_q;
      a_neg_d      = a_neg_q;
      b_neg_d      = b_neg_q;
      cnt_d        = cnt_q;
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_tag_d    = out_tag_q;
      in_ready     = (state_q == S_IDLE) && !flush && !rst;

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               op_d    = op_in;
               tag_d   = in_tag;
               a_neg_d = in_a_neg;
               b_neg_d = in_b_neg;
               opnd_d  = in_mul ? in_a_mag : in_b_mag;
               acc_d   = {{W{1'b0}}, (in_mul ? in_b_mag : in_a_mag)};
               cnt_d   = CNT_W'(W - 1);
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            if (q_mul) acc_d = {mul_sum, acc_q[W-1:1]};
            else acc_d = {(div_ge ? div_sub[W-1:0] : div_rem_sh[W-1:0]), acc_q[W-2:0], div_ge};
            if (cnt_q == '0) state_d = S_FIX;
            else cnt_d = cnt_q - 1'b1;
         end
         S_FIX: begin
            out_result_d = fix_result;
            out_tag_d    = tag_q;
            out_valid_d  = 1'b1;
            state_d      = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (flush) begin
         out_valid_d = 1'b0;
         state_d     = S_IDLE;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state_q      <= S_IDLE;
         op_q         <= OP_MUL;
         tag_q        <= '0;
         opnd_q       <= '0;
         acc_q        <= '0;
         a_neg_q      <= 1'b0;
         b_neg_q      <= 1'b0;
         cnt_q        <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_tag_q    <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         tag_q        <= tag_d;
         opnd_q       <= opnd_d;
         acc_q        <= acc_d;
         a_neg_q      <= a_neg_d;
         b_neg_q      <= b_neg_d;
         cnt_q        <= cnt_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_tag_q    <= out_tag_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed test-plan vectors, randomised
// ops against a behavioural model, backpressure, flush and reset mid-op.
module tb_mdu_iter;

   localparam int W  = 32;
   localparam int TW = 5;
   localparam int LAT = W + 1;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [2:0]    in_op;
   logic [W-1:0]  in_a, in_b, out_result;
   logic [TW-1:0] in_tag, out_tag;

   mdu_iter #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0]  res;
      logic [TW-1:0] tag;
   } exp_t;
   exp_t sb_q[$];

   int n_tests = 0;
   int n_fail  = 0;
   int acc_cyc = 0;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      longint      sa, sb, sr;
      logic [63:0] t, ua, ub;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (op)
         3'd0: begin t = ua * ub; return t[W-1:0]; end
         3'd1: begin sr = sa * sb; t = sr; return t[63:32]; end
         3'd2: begin t = ua * ub; return t[63:32]; end
         3'd3: begin if (b == 0) return '1; sr = sa / sb; t = sr; return t[W-1:0]; end
         3'd4: begin if (b == 0) return '1; return a / b; end
         3'd5: begin if (b == 0) return a; sr = sa % sb; t = sr; return t[W-1:0]; end
         3'd6: begin if (b == 0) return a; return a % b; end
         default: return '0;
      endcase
   endfunction

   // Wait (bounded) for in_ready, present one request, and record the accept cycle.
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] tag, input logic [W-1:0] exp_res, input bit push);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 0, 1);
         return;
      end
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
      if (push) sb_q.push_back('{res: exp_res, tag: tag});
      @(posedge clk); #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
      in_a     = $urandom;
      in_b     = $urandom;
      in_op    = 3'($urandom_range(0, 7));
      in_tag   = 5'($urandom);
   endtask

   // Wait for the result, check latency/value/tag, optionally hold backpressure, then release.
   task automatic collect(input string name, input int hold);
      int   n = 0;
      exp_t e;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!out_valid) begin
         check({name, "_timeout"}, 0, 1);
         return;
      end
      check({name, "_lat"}, 64'(cyc - acc_cyc), 64'(LAT));
      if (sb_q.size() == 0) begin
         check({name, "_unexpected"}, 1, 0);
         return;
      end
      e = sb_q.pop_front();
      check({name, "_res"}, 64'(out_result), 64'(e.res));
      check({name, "_tag"}, 64'(out_tag), 64'(e.tag));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({name, "_hold_valid"}, 64'(out_valid), 1);
         check({name, "_hold_res"}, 64'(out_result), 64'(e.res));
         check({name, "_hold_tag"}, 64'(out_tag), 64'(e.tag));
         check({name, "_hold_in_ready"}, 64'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({name, "_released"}, 64'(out_valid), 0);
      check({name, "_idle_ready"}, 64'(in_ready), 1);
   endtask

   task automatic run(input string name, input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [TW-1:0] tag, input logic [W-1:0] exp_res);
      issue(op, a, b, tag, exp_res, 1'b1);
      collect(name, 0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 0);
      check("rst_out_valid", 64'(out_valid), 0);
      check("rst_out_result", 64'(out_result), 0);
      check("rst_out_tag", 64'(out_tag), 0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 64'(in_ready), 1);

      run("mul",    3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB);
      run("mulh",   3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 5'd2,  32'hFFFF_FFFF);
      run("mulhu",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'hFFFF_FFFE);
      run("div",    3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 5'd3,  32'hFFFF_FFFD);
      run("mod",    3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4,  32'hFFFF_FFFF);
      run("divu",   3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'h7FFF_FFFC);
      run("div0",   3'd3, 32'h0000_1234, 32'h0000_0000, 5'd6,  32'hFFFF_FFFF);
      run("mod0",   3'd5, 32'h0000_1234, 32'h0000_0000, 5'd7,  32'h0000_1234);
      run("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h8000_0000);
      run("modovf", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h0000_0000);
      run("rsvd",   3'd7, 32'h1234_5678, 32'h0000_0003, 5'd10, 32'h0000_0000);

      // Backpressure, then the next request accepted the cycle after release.
      issue(3'd0, 32'd1000, 32'd1000, 5'd21, 32'd1_000_000, 1'b1);
      collect("bp", 10);
      run("after_bp", 3'd6, 32'd100, 32'd7, 5'd22, 32'd2);

      for (int i = 0; i < 12; i++) begin
         logic [2:0]    op;
         logic [W-1:0]  a, b;
         logic [TW-1:0] tg;
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = (i % 4 == 0) ? 32'd0 : ((i % 3 == 1) ? 32'($urandom_range(1, 15)) : $urandom);
         if (i % 5 == 2) a = -a;
         tg = 5'($urandom);
         run($sformatf("rand%0d", i), op, a, b, tg, ref_model(op, a, b));
      end

      // Flush five cycles into CALC; the discarded request must never produce a result.
      issue(3'd3, 32'h7654_3210, 32'd3, 5'd30, 32'd0, 1'b0);
      repeat (5) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      check("flush_in_ready", 64'(in_ready), 0);
      check("flush_out_valid", 64'(out_valid), 0);
      flush = 1'b0;
      #1;
      check("flush_idle_ready", 64'(in_ready), 1);
      run("flush_divu", 3'd4, 32'd100, 32'd7, 5'd11, 32'd14);

      // Same with reset: all outputs cleared by the reset edge.
      issue(3'd1, 32'hDEAD_BEEF, 32'h1357_9BDF, 5'd29, 32'd0, 1'b0);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_in_ready", 64'(in_ready), 0);
      check("rst_mid_out_valid", 64'(out_valid), 0);
      check("rst_mid_out_result", 64'(out_result), 0);
      check("rst_mid_out_tag", 64'(out_tag), 0);
      rst = 1'b0;
      #1;
      run("rst_divu", 3'd4, 32'd100, 32'd7, 5'd12, 32'd14);

      check("sb_empty", 64'(sb_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
